// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode presets and raster-size helpers.
package vga_pkg;

    // Complete timing description of one video mode (sizes in pixels / lines).
    typedef struct packed {
        int h_sync;
        int h_bp;
        int h_active;
        int h_fp;
        int v_sync;
        int v_bp;
        int v_active;
        int v_fp;
        int h_pol;
        int v_pol;
    } vga_timing_t;

    typedef enum logic [0:0] {
        VGA_MODE_640X480_60 = 1'b0,
        VGA_MODE_800X600_72 = 1'b1
    } vga_mode_e;

    // Standard timing sets; 640x480@60 uses active-low syncs, 800x600@72 active-high.
    function automatic vga_timing_t vga_preset(input vga_mode_e mode);
        vga_timing_t t;
        case (mode)
            VGA_MODE_800X600_72: t = '{h_sync: 120, h_bp: 64, h_active: 800, h_fp: 56,
                                       v_sync: 6,   v_bp: 23, v_active: 600, v_fp: 37,
                                       h_pol: 1,    v_pol: 1};
            default:             t = '{h_sync: 96,  h_bp: 48, h_active: 640, h_fp: 16,
                                       v_sync: 2,   v_bp: 33, v_active: 480, v_fp: 10,
                                       h_pol: 0,    v_pol: 0};
        endcase
        return t;
    endfunction

    localparam vga_timing_t VGA_DEFAULT = vga_preset(VGA_MODE_640X480_60);

    // Pixels per complete line, including sync and porches.
    function automatic int h_total(input int sync_w, input int bp, input int active, input int fp);
        return sync_w + bp + active + fp;
    endfunction

    // Lines per complete frame, including sync and porches.
    function automatic int v_total(input int sync_w, input int bp, input int active, input int fp);
        return sync_w + bp + active + fp;
    endfunction

    // True when a non-negative value can be held in an unsigned field of the given width.
    function automatic bit fits_width(input int value, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return (value < (1 << width));
    endfunction

endpackage

// File: rtl/vga_tag_pipe.sv
// Clock-enable gated delay line; DEPTH=0 degenerates into a plain wire.
module vga_tag_pipe #(
    parameter int W     = 3,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_rst_val,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Nothing to delay; the clocking inputs are deliberately left idle.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_ce, i_rst_val};
            assign o_dout   = i_din;
        end else begin : g_delay
            logic [W-1:0] r_stage [DEPTH];

            // Shift one position per enabled tick; reset loads the idle value everywhere.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= i_rst_val;
                    end
                end else if (i_ce) begin
                    r_stage[0] <= i_din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: counters, sync, frame-buffer addressing and
// a latency-matched output stage so sync, de and RGB leave together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA_DEFAULT.h_sync,
    parameter int H_BP     = VGA_DEFAULT.h_bp,
    parameter int H_ACTIVE = VGA_DEFAULT.h_active,
    parameter int H_FP     = VGA_DEFAULT.h_fp,
    parameter int V_SYNC   = VGA_DEFAULT.v_sync,
    parameter int V_BP     = VGA_DEFAULT.v_bp,
    parameter int V_ACTIVE = VGA_DEFAULT.v_active,
    parameter int V_FP     = VGA_DEFAULT.v_fp,
    parameter int H_POL    = VGA_DEFAULT.h_pol,
    parameter int V_POL    = VGA_DEFAULT.v_pol,
    parameter int PIPE_LAT = 1,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_ce,
    input  logic [3*COLOR_W-1:0]   vga_data,
    output logic [CNT_W-1:0]       h_addr,
    output logic [CNT_W-1:0]       v_addr,
    output logic                   addr_valid,
    output logic                   frame_start,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] C_H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_START    = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] C_V_START    = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] C_H_ACT_LAST = CNT_W'(H_START + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_V_ACT_LAST = CNT_W'(V_START + V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_H_SYNC     = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] C_V_SYNC     = CNT_W'(V_SYNC);
    localparam logic             C_H_POL      = (H_POL != 0);
    localparam logic             C_V_POL      = (V_POL != 0);

    // Reject configurations the counters or the delay line cannot represent.
    generate
        if (!fits_width(H_TOTAL - 1, CNT_W) || !fits_width(V_TOTAL - 1, CNT_W)) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too small for the configured raster");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_pipe_lat
            $error("vga_timing_gen: PIPE_LAT must be in 0..4");
        end
    endgenerate

    logic [CNT_W-1:0]     r_h_cnt;
    logic [CNT_W-1:0]     r_v_cnt;
    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_h_vis;
    logic                 w_v_vis;
    logic                 w_hs_raw;
    logic                 w_vs_raw;
    logic [2:0]           w_tag_in;
    logic [2:0]           w_tag_out;
    logic                 w_de_next;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_de;
    logic [3*COLOR_W-1:0] r_rgb;

    assign w_h_last = (r_h_cnt == C_H_LAST);
    assign w_v_last = (r_v_cnt == C_V_LAST);

    // Pixel and line counters; the line counter steps only when the pixel counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_ce) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Counter-phase decode: visible window, addresses, raw (active-high) syncs.
    assign w_h_vis     = (r_h_cnt >= C_H_START) && (r_h_cnt <= C_H_ACT_LAST);
    assign w_v_vis     = (r_v_cnt >= C_V_START) && (r_v_cnt <= C_V_ACT_LAST);
    assign addr_valid  = w_h_vis & w_v_vis;
    assign h_addr      = addr_valid ? (r_h_cnt - C_H_START) : '0;
    assign v_addr      = addr_valid ? (r_v_cnt - C_V_START) : '0;
    assign w_hs_raw    = (r_h_cnt < C_H_SYNC);
    assign w_vs_raw    = (r_v_cnt < C_V_SYNC);
    assign frame_start = pix_ce & (r_h_cnt == '0) & (r_v_cnt == '0);

    // Tags travel alongside the frame-buffer read so they meet the returning pixel.
    assign w_tag_in = {w_hs_raw, w_vs_raw, addr_valid};

    vga_tag_pipe #(
        .W     (3),
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_ce      (pix_ce),
        .i_rst_val (3'b000),
        .i_din     (w_tag_in),
        .o_dout    (w_tag_out)
    );

    assign w_de_next = w_tag_out[0];

    // Output register: apply sync polarity and blank RGB outside the visible window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= ~C_H_POL;
            r_vsync <= ~C_V_POL;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else if (pix_ce) begin
            r_hsync <= C_H_POL ? w_tag_out[2] : ~w_tag_out[2];
            r_vsync <= C_V_POL ? w_tag_out[1] : ~w_tag_out[1];
            r_de    <= w_de_next;
            r_rgb   <= w_de_next ? vga_data : '0;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign vga_r = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign vga_g = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign vga_b = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a miniature raster with a 2-tick frame-buffer model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int V_ACTIVE = 5;
    localparam int V_FP     = 1;
    localparam int H_POL    = 0;
    localparam int V_POL    = 1;
    localparam int PIPE_LAT = 2;
    localparam int COLOR_W  = 4;
    localparam int CNT_W    = 8;
    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pix_ce;
    logic [3*COLOR_W-1:0] vga_data;
    logic [CNT_W-1:0]     h_addr;
    logic [CNT_W-1:0]     v_addr;
    logic                 addr_valid;
    logic                 frame_start;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .H_POL(H_POL), .V_POL(V_POL), .PIPE_LAT(PIPE_LAT),
        .COLOR_W(COLOR_W), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .vga_data    (vga_data),
        .h_addr      (h_addr),
        .v_addr      (v_addr),
        .addr_valid  (addr_valid),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } out_t;

    out_t        sb_q[$];
    logic [11:0] ram_q[$];
    out_t        exp_out;
    int          m_h;
    int          m_v;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h (model h=%0d v=%0d)",
                     tag, $time, got, exp, m_h, m_v);
        end
    endtask

    function automatic out_t reset_out();
        out_t r;
        r.hs  = (H_POL == 0);
        r.vs  = (V_POL == 0);
        r.de  = 1'b0;
        r.rgb = 12'h000;
        return r;
    endfunction

    // Expected pins for a given raster position, independent of any pipeline.
    function automatic out_t model_out(input int h, input int v);
        out_t r;
        logic hs_raw;
        logic vs_raw;
        logic vis;
        hs_raw = (h < H_SYNC);
        vs_raw = (v < V_SYNC);
        vis    = (h >= H_START) && (h < H_START + H_ACTIVE) &&
                 (v >= V_START) && (v < V_START + V_ACTIVE);
        r.hs  = (H_POL != 0) ? hs_raw : ~hs_raw;
        r.vs  = (V_POL != 0) ? vs_raw : ~vs_raw;
        r.de  = vis;
        r.rgb = vis ? {4'(h - H_START), 4'(v - V_START), 4'hA} : 12'h000;
        return r;
    endfunction

    task automatic reset_model();
        m_h = 0;
        m_v = 0;
        sb_q.delete();
        ram_q.delete();
        for (int i = 0; i < PIPE_LAT; i++) begin
            sb_q.push_back(reset_out());
            ram_q.push_back(12'hFFF);
        end
        exp_out  = reset_out();
        vga_data = 12'hFFF;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ":hsync"}, hsync, exp_out.hs);
        check_val({tag, ":vsync"}, vsync, exp_out.vs);
        check_val({tag, ":de"},    de,    exp_out.de);
        check_val({tag, ":rgb"},   {vga_r, vga_g, vga_b}, exp_out.rgb);
    endtask

    // One clk cycle, entered and left just after a falling edge.
    task automatic step(input logic ce);
        logic ev;
        pix_ce = ce;
        if (ce) vga_data = ram_q.pop_front();
        #1;
        ev = (m_h >= H_START) && (m_h < H_START + H_ACTIVE) &&
             (m_v >= V_START) && (m_v < V_START + V_ACTIVE);
        check_val("addr_valid",  addr_valid,  ev);
        check_val("h_addr",      h_addr,      ev ? m_h - H_START : 0);
        check_val("v_addr",      v_addr,      ev ? m_v - V_START : 0);
        check_val("frame_start", frame_start, ce && (m_h == 0) && (m_v == 0));
        if (ce) begin
            sb_q.push_back(model_out(m_h, m_v));
            ram_q.push_back(addr_valid ? {h_addr[3:0], v_addr[3:0], 4'hA} : 12'hFFF);
        end
        @(negedge clk);
        if (ce) begin
            exp_out = sb_q.pop_front();
            if (m_h == H_TOTAL - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        check_outputs("pix");
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        pix_ce   = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        check_outputs("reset");
        check_val("reset:h_addr",      h_addr,      0);
        check_val("reset:addr_valid",  addr_valid,  0);
        check_val("reset:frame_start", frame_start, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < FRAME + 20; i++) step(1'b1);
        $display("[TB] continuous pix_ce: %0d ticks", FRAME + 20);

        for (int i = 0; i < 4 * FRAME + 8; i++) step((i % 4) == 0);
        $display("[TB] pix_ce 1-in-4: %0d clks", 4 * FRAME + 8);

        for (int i = 0; i < 300; i++) step($urandom_range(0, 2) == 0);
        $display("[TB] random pix_ce: 300 clks");

        guard = 0;
        while (!((m_v == V_START + 2) && (m_h == H_START + 5)) && guard < 2 * FRAME) begin
            step(1'b1);
            guard++;
        end
        check_val("seek_midframe_budget", guard < 2 * FRAME, 1);
        check_val("midframe:de", de, 1);
        pix_ce = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_out = reset_out();
        check_outputs("async_reset");
        check_val("async_reset:h_addr",     h_addr,     0);
        check_val("async_reset:v_addr",     v_addr,     0);
        check_val("async_reset:addr_valid", addr_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        check_outputs("after_reset");
        $display("[TB] mid-frame reset applied");

        for (int i = 0; i < FRAME + 10; i++) step(1'b1);
        $display("[TB] post-reset frame: %0d ticks", FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
